data_memory: RTL and testbench



---
 rtl/dm_pkg.sv | 18 +
 rtl/data_memory_if.sv | 23 ++
 rtl/data_memory_load_store_align.sv | 75 +++++++
 rtl/data_memory.sv | 80 ++++++++
 tb/tb_data_memory.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the RV32I data memory stage: funct3 load/store
// encodings and the clear/ready state machine states.
package dm_pkg;

  typedef enum logic [2:0] {
    DM_B  = 3'b000,
    DM_H  = 3'b001,
    DM_W  = 3'b010,
    DM_BU = 3'b100,
    DM_HU = 3'b101
  } dm_ctrl_e;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dm_state_e;

endpackage

// File: rtl/data_memory_if.sv
// Bus between the datapath (ALU result, rs2, control unit) and the data memory.
interface data_memory_if;

  logic [31:0] Address;
  logic [31:0] DataWr;
  logic        DMWr;
  logic [2:0]  DMCtrl;
  logic [31:0] DataRd;
  logic        misaligned;
  logic        illegal;
  logic        busy;

  modport master (
    output Address, DataWr, DMWr, DMCtrl,
    input  DataRd, misaligned, illegal, busy
  );

  modport slave (
    input  Address, DataWr, DMWr, DMCtrl,
    output DataRd, misaligned, illegal, busy
  );

endinterface

// File: rtl/data_memory_load_store_align.sv
// Combinational lane logic: store byte-enables and replication, load lane
// extraction with sign/zero extension, and the misaligned/illegal flags.
module load_store_align
  import dm_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [2:0]  ctrl,
  input  logic        wr,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        illegal
);

  logic        fault;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign fault    = misaligned | illegal;
  assign sel_byte = 8'(rword >> {lane, 3'b000});
  assign sel_half = lane[1] ? rword[31:16] : rword[15:0];

  // The two flags are deliberately independent: an encoding with no width
  // can never be misaligned, even when it is also illegal.
  always_comb begin
    misaligned = 1'b0;
    unique case (ctrl)
      DM_H, DM_HU: misaligned = lane[0];
      DM_W:        misaligned = (lane != 2'b00);
      default:     misaligned = 1'b0;
    endcase

    if (wr)
      illegal = !(ctrl inside {DM_B, DM_H, DM_W});
    else
      illegal = ctrl inside {3'b011, 3'b110, 3'b111};
  end

  always_comb begin
    rdata = '0;
    unique case (ctrl)
      DM_B:    rdata = {{24{sel_byte[7]}}, sel_byte};
      DM_BU:   rdata = {24'd0, sel_byte};
      DM_H:    rdata = {{16{sel_half[15]}}, sel_half};
      DM_HU:   rdata = {16'd0, sel_half};
      DM_W:    rdata = rword;
      default: rdata = '0;
    endcase
    if (fault)
      rdata = '0;
  end

  always_comb begin
    byte_en   = 4'b0000;
    wdata_rep = wdata;
    unique case (ctrl)
      DM_B: begin
        byte_en   = 4'b0001 << lane;
        wdata_rep = {4{wdata[7:0]}};
      end
      DM_H: begin
        byte_en   = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      DM_W:    byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
    if (fault || !wr)
      byte_en = 4'b0000;
  end

endmodule

// File: rtl/data_memory.sv
// Word-organised data memory with byte-lane stores and asynchronous reads.
// After reset a sweep zero-fills the array; busy holds the pipeline until done.
module data_memory
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic clk,
  input  logic rst_n,
  data_memory_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  dm_state_e         state, state_next;
  logic [ADDR_W-1:0] idx, idx_next;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       rword;
  logic [3:0]        byte_en;
  logic [31:0]       wdata_rep;
  logic [31:0]       rdata;
  logic              mis_raw, ill_raw;
  logic              ready;

  assign word_idx = bus.Address[ADDR_W+1:2];
  assign rword    = mem[word_idx];
  assign ready    = rst_n && (state == READY);

  load_store_align u_align (
    .lane       (bus.Address[1:0]),
    .ctrl       (bus.DMCtrl),
    .wr         (bus.DMWr),
    .wdata      (bus.DataWr),
    .rword      (rword),
    .byte_en    (byte_en),
    .wdata_rep  (wdata_rep),
    .rdata      (rdata),
    .misaligned (mis_raw),
    .illegal    (ill_raw)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    if (state == CLEAR) begin
      idx_next = idx + 1'b1;
      if (idx == ADDR_W'(DEPTH_WORDS - 1))
        state_next = READY;
    end
  end

  // Reset edges never touch the array; the sweep owns it until READY.
  always_ff @(posedge clk) begin
    if (rst_n && state == CLEAR) begin
      mem[idx] <= '0;
    end else if (ready && bus.DMWr) begin
      for (int i = 0; i < 4; i++)
        if (byte_en[i])
          mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
    end
  end

  assign bus.busy       = !ready;
  assign bus.DataRd     = ready ? rdata : 32'd0;
  assign bus.misaligned = ready && mis_raw;
  assign bus.illegal    = ready && ill_raw;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever a check is flagged valid.
module tb_data_memory;
  import dm_pkg::*;

  localparam int DEPTH = 16;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        mis;
    logic        ill;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic chk_valid = 1'b0;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_bad    = 0;
  int   busy_cnt;

  always #5 clk = ~clk;

  data_memory_if bus ();

  data_memory #(.DEPTH_WORDS(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic checkOutput(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got data=0x%08h mis=%0b ill=%0b, want data=0x%08h mis=%0b ill=%0b",
               name, act[33:2], act[1], act[0], exp[33:2], exp[1], exp[0]);
    end
  endtask

  // Drives one access just after a rising edge; it commits on the next edge.
  task automatic applyStimulus(input string name, input logic wr, input logic [2:0] ctrl,
                               input logic [31:0] addr, input logic [31:0] data, input logic check,
                               input logic [31:0] exp_data, input logic exp_mis, input logic exp_ill);
    exp_t e;
    bus.DMWr    = wr;
    bus.DMCtrl  = ctrl;
    bus.Address = addr;
    bus.DataWr  = data;
    if (check) begin
      e.name = name; e.data = exp_data; e.mis = exp_mis; e.ill = exp_ill;
      sb.push_back(e);
      chk_valid = 1'b1;
    end
    @(negedge clk);
    #1 chk_valid = 1'b0;
    @(posedge clk);
    #1 bus.DMWr = 1'b0;
  endtask

  task automatic countBusy(output int cnt);
    cnt = 0;
    while (bus.busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_bad++;
          $display("[TB] FAIL scoreboard_underflow: got no entry, want one");
        end else begin
          e = sb.pop_front();
          checkOutput(e.name, {bus.DataRd, bus.misaligned, bus.illegal}, {e.data, e.mis, e.ill});
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    bus.Address = '0;
    bus.DataWr  = '0;
    bus.DMWr    = 1'b0;
    bus.DMCtrl  = DM_W;

    // Clear sequence after a two-cycle reset
    rst_n = 1'b0;
    @(posedge clk); #1;
    applyStimulus("reset_outputs", 1'b0, 3'b011, 32'h1, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    checkOutput("busy_in_reset", {33'd0, bus.busy}, {33'd0, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;
    countBusy(busy_cnt);
    checkOutput("busy_len_reset", 34'(busy_cnt), 34'(DEPTH));
    @(posedge clk); #1;
    applyStimulus("lw_3c_cleared", 1'b0, DM_W, 32'h3C, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);

    // Reset mid-clear with a store held throughout
    @(negedge clk);
    rst_n = 1'b0;
    bus.DMWr = 1'b1; bus.DMCtrl = DM_W; bus.Address = 32'h0; bus.DataWr = 32'hCAFEF00D;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    countBusy(busy_cnt);
    bus.DMWr = 1'b0;
    checkOutput("busy_len_restart", 34'(busy_cnt), 34'(DEPTH));
    @(posedge clk); #1;
    applyStimulus("lw_0_store_ignored", 1'b0, DM_W, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);

    // Lane stores
    applyStimulus("sw_10", 1'b1, DM_W, 32'h10, 32'h11223344, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus("sb_11", 1'b1, DM_B, 32'h11, 32'h000000AA, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus("sh_12", 1'b1, DM_H, 32'h12, 32'h0000BEEF, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus("lw_10_lanes", 1'b0, DM_W, 32'h10, 32'h0, 1'b1, 32'hBEEFAA44, 1'b0, 1'b0);

    // Extension
    applyStimulus("lb_11",  1'b0, DM_B,  32'h11, 32'h0, 1'b1, 32'hFFFFFFAA, 1'b0, 1'b0);
    applyStimulus("lbu_11", 1'b0, DM_BU, 32'h11, 32'h0, 1'b1, 32'h000000AA, 1'b0, 1'b0);
    applyStimulus("lh_12",  1'b0, DM_H,  32'h12, 32'h0, 1'b1, 32'hFFFFBEEF, 1'b0, 1'b0);
    applyStimulus("lhu_12", 1'b0, DM_HU, 32'h12, 32'h0, 1'b1, 32'h0000BEEF, 1'b0, 1'b0);
    applyStimulus("lb_10",  1'b0, DM_B,  32'h10, 32'h0, 1'b1, 32'h00000044, 1'b0, 1'b0);

    // Faults
    applyStimulus("sw_12_misaligned", 1'b1, DM_W, 32'h12, 32'hDEADBEEF, 1'b1, 32'h0, 1'b1, 1'b0);
    applyStimulus("lw_10_after_mis", 1'b0, DM_W, 32'h10, 32'h0, 1'b1, 32'hBEEFAA44, 1'b0, 1'b0);
    applyStimulus("lw_ctrl011", 1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
    applyStimulus("ld_ctrl011_odd", 1'b0, 3'b011, 32'h11, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
    applyStimulus("lhu_13_mis", 1'b0, DM_HU, 32'h13, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
    applyStimulus("st_bu_illegal", 1'b1, DM_BU, 32'h10, 32'h00000055, 1'b1, 32'h0, 1'b0, 1'b1);
    applyStimulus("lw_10_after_ill", 1'b0, DM_W, 32'h10, 32'h0, 1'b1, 32'hBEEFAA44, 1'b0, 1'b0);

    // Wrap and read-during-write
    applyStimulus("sw_wrap", 1'b1, DM_W, 32'(DEPTH*4 + 4), 32'h12345678, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus("lw_4_wrapped", 1'b0, DM_W, 32'h4, 32'h0, 1'b1, 32'h12345678, 1'b0, 1'b0);
    applyStimulus("sw_4_rdw_old", 1'b1, DM_W, 32'h4, 32'h9ABCDEF0, 1'b1, 32'h12345678, 1'b0, 1'b0);
    applyStimulus("lw_4_rdw_new", 1'b0, DM_W, 32'h4, 32'h0, 1'b1, 32'h9ABCDEF0, 1'b0, 1'b0);

    @(negedge clk);
    checkOutput("scoreboard_drained", 34'(sb.size()), 34'd0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
